seq_binary_to_bcd: RTL

Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one input bit per clock. It generalises the team's combinational converter to arbitrary input width and digit count, adds a start/ready/valid handshake, and flags overflow with saturation. It sits between counter or measurement logic and the seven-segment display drivers, where one conversion every BIN_WIDTH+2 cycles is ample.

---
 rtl/seq_binary_to_bcd.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_binary_to_bcd.sv
// seq_binary_to_bcd
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per clock, with a start/ready/valid handshake. Results that do
// not fit in DIGITS decimal digits saturate to all nines and raise overflow.
// Optional feature macro: BCD_BLANK_EN enables registered leading-zero blank
// flags. Without it the blank port is driven constant zero.

module seq_binary_to_bcd #(
   parameter int BIN_WIDTH = 16,
   parameter int DIGITS    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_WIDTH-1:0]  binary,
   output logic                  ready,
   output logic                  busy,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state;
   logic [BIN_WIDTH-1:0] shreg;
   logic [ACC_W-1:0]     acc;
   logic [ACC_W-1:0]     adj;
   logic [ACC_W-1:0]     result;
   logic                 ovf_flag;
   logic [CNT_W-1:0]     cnt;

   // Add-3 correction for every digit that is 5 or more, ahead of the shift.
   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      adj = acc;
      for (int k = 0; k < DIGITS; k++) begin
         if (acc[4*k +: 4] > 4'd4) begin
            adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
         end
      end
   end

   // Value presented at the end of a conversion: saturate to all nines on overflow.
   always_comb begin
      result = ovf_flag ? {DIGITS{4'h9}} : acc;
   end

   // Control FSM, datapath and registered outputs.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ready    <= 1'b1;
         busy     <= 1'b0;
         valid    <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         shreg    <= '0;
         acc      <= '0;
         ovf_flag <= 1'b0;
         cnt      <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg    <= binary;
                  acc      <= '0;
                  ovf_flag <= 1'b0;
                  cnt      <= CNT_W'(BIN_WIDTH);
                  state    <= SHIFT;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               acc   <= {adj[ACC_W-2:0], shreg[BIN_WIDTH-1]};
               shreg <= shreg << 1;
               cnt   <= cnt - CNT_W'(1);
               if (adj[ACC_W-1]) begin
                  ovf_flag <= 1'b1;
               end
               if (cnt == CNT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               bcd      <= result;
               overflow <= ovf_flag;
               valid    <= 1'b1;
               state    <= IDLE;
               ready    <= 1'b1;
               busy     <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BCD_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

   logic [DIGITS-1:0] blank_next;
   logic              zero_above;

   // Leading-zero flags: digit k blanks when it and every higher digit are zero.
   always_comb begin
      blank_next = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above    = zero_above & (result[4*k +: 4] == 4'h0);
         blank_next[k] = zero_above;
      end
   end

   // Blank flags update on the same edge as bcd.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank <= BLANK_RST;
      end else if (state == DONE) begin
         blank <= blank_next;
      end
   end
`else
   assign blank = '0;
`endif

endmodule
